// File: rtl/spigot_pkg.sv
// Shared types, helpers and default configuration for the e spigot engine.
package spigot_pkg;

    localparam int NTERMS_DEF  = 32;
    localparam int RADIX_DEF   = 10;
    localparam int NDIGITS_DEF = 30;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        HEAD,
        LOAD,
        DIV,
        STORE,
        EMIT,
        DONE
    } state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) r = k + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spigot_e_engine_if.sv
// Control and digit-stream handshake between the engine and its consumer.
interface spigot_e_engine_if
    import spigot_pkg::*;
#(
    parameter int DGW = clog2(RADIX_DEF)
);
    logic           start;
    logic           abort;
    logic           out_ready;
    logic           out_valid;
    logic [DGW-1:0] out_digit;
    logic           out_first;
    logic           out_last;
    logic           busy;
    logic           done;

    modport master (
        output start, abort, out_ready,
        input  out_valid, out_digit, out_first, out_last, busy, done
    );

    modport slave (
        input  start, abort, out_ready,
        output out_valid, out_digit, out_first, out_last, busy, done
    );
endinterface

// File: rtl/spigot_e_engine_divmod.sv
// Restoring divider: one quotient bit per cycle, XW cycles per division.
// done marks the last iteration cycle; results are valid the cycle after.
module spigot_divmod
    import spigot_pkg::*;
#(
    parameter int XW = 9,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          done,
    output logic [XW-1:0] quotient,
    output logic [CW-1:0] remainder
);
    localparam int SW = clog2(XW + 1);

    logic [SW-1:0] steps;
    logic [XW-1:0] quo;
    logic [CW-1:0] rem;
    logic [CW:0]   trial;
    logic          fits;

    // Shift the next dividend bit into the partial remainder and test it.
    always_comb begin
        trial = {rem, quo[XW-1]};
        fits  = (trial >= {1'b0, divisor});
    end

    // Iteration register: load on start, then one restoring step per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            steps <= '0;
            quo   <= '0;
            rem   <= '0;
        end else if (start) begin
            steps <= SW'(XW);
            quo   <= dividend;
            rem   <= '0;
        end else if (steps != '0) begin
            steps <= steps - 1'b1;
            quo   <= {quo[XW-2:0], fits};
            rem   <= fits ? CW'(trial - {1'b0, divisor}) : trial[CW-1:0];
        end
    end

    assign done      = (steps == SW'(1));
    assign quotient  = quo;
    assign remainder = rem;
endmodule

// File: rtl/spigot_e_engine.sv
// Streams the digits of e with the mixed-radix spigot (cells start at 1).
//   state | meaning
//   IDLE  | waiting for start
//   INIT  | cells <= 1, q <= 0, i <= NTERMS+1
//   HEAD  | offering the integer digit 2
//   LOAD  | x = RADIX*a[i] + q, kick divider by i
//   DIV   | divider iterating
//   STORE | a[i] <= x mod i, q <= x div i
//   EMIT  | offering fractional digit q
//   DONE  | run complete, waiting for start
module spigot_e_engine
    import spigot_pkg::*;
#(
    parameter int NTERMS  = NTERMS_DEF,
    parameter int RADIX   = RADIX_DEF,
    parameter int NDIGITS = NDIGITS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    spigot_e_engine_if.slave bus
);
    localparam int CW  = clog2(NTERMS + 2);
    localparam int XW  = clog2(RADIX * (NTERMS + 2));
    localparam int DGW = clog2(RADIX);
    localparam int NW  = 8;

    localparam logic [CW-1:0] I_TOP   = CW'(NTERMS + 1);
    localparam logic [CW-1:0] I_LAST  = CW'(2);
    localparam logic [XW-1:0] RADIX_X = XW'(RADIX);
    localparam logic [NW-1:0] N_LAST  = NW'(NDIGITS - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cells [2:NTERMS+1];
    logic [CW-1:0]  i;
    logic [XW-1:0]  q;
    logic [XW-1:0]  x;
    logic [NW-1:0]  count;
    logic           div_start, div_done;
    logic [XW-1:0]  div_quo;
    logic [CW-1:0]  div_rem;
    logic           valid, first, last;
    logic [DGW-1:0] digit;

    assign x = RADIX_X * XW'(cells[i]) + q;

    spigot_divmod #(.XW(XW), .CW(CW)) u_divmod (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (x),
        .divisor   (i),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; abort overrides everything.
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        valid     = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        digit     = '0;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = INIT;
            INIT:       state_nxt = HEAD;
            HEAD: begin
                valid = 1'b1;
                first = 1'b1;
                digit = DGW'(2);
                if (bus.out_ready) state_nxt = LOAD;
            end
            LOAD: begin
                div_start = 1'b1;
                state_nxt = DIV;
            end
            DIV:   if (div_done) state_nxt = STORE;
            STORE: state_nxt = (i == I_LAST) ? EMIT : LOAD;
            EMIT: begin
                valid = 1'b1;
                last  = (count == N_LAST);
                digit = q[DGW-1:0];
                if (bus.out_ready) state_nxt = (count == N_LAST) ? DONE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    // Scalar datapath: carry q, cell index i and digit count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            i     <= '0;
            count <= '0;
        end else if (!bus.abort) begin
            case (state)
                INIT: begin
                    q     <= '0;
                    i     <= I_TOP;
                    count <= '0;
                end
                STORE: begin
                    q <= div_quo;
                    if (i != I_LAST) i <= i - 1'b1;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        count <= count + 1'b1;
                        q     <= '0;
                        i     <= I_TOP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cell array: no reset, contents only matter after INIT.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.abort) begin
            if (state == INIT) begin
                for (int k = 2; k <= NTERMS + 1; k++) cells[k] <= CW'(1);
            end else if (state == STORE) begin
                cells[i] <= div_rem;
            end
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_digit = digit;
    assign bus.out_first = first;
    assign bus.out_last  = last;
    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_spigot_e_engine.sv
// Directed bench: decimal engine (defaults) and a hex engine (RADIX=16, NDIGITS=8).
module tb_spigot_e_engine;
    import spigot_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    int exp_dec [31] = '{2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3,6,0,2,8,7,4,7,1,3,5,2};
    int exp_hex [9]  = '{2,11,7,14,1,5,1,6,2};

    spigot_e_engine_if #(.DGW(4)) bus0 ();
    spigot_e_engine_if #(.DGW(4)) bus1 ();

    spigot_e_engine u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    spigot_e_engine #(.RADIX(16), .NDIGITS(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // {valid, digit[3:0], first, last, busy, done}
    function automatic logic [8:0] out_vec(input int w);
        if (w == 0)
            return {bus0.out_valid, bus0.out_digit, bus0.out_first, bus0.out_last, bus0.busy, bus0.done};
        return {bus1.out_valid, bus1.out_digit, bus1.out_first, bus1.out_last, bus1.busy, bus1.done};
    endfunction

    task automatic set_in(input int w, input logic st, input logic ab, input logic rd);
        if (w == 0) begin
            bus0.start = st; bus0.abort = ab; bus0.out_ready = rd;
        end else begin
            bus1.start = st; bus1.abort = ab; bus1.out_ready = rd;
        end
    endtask

    task automatic pulse_start(input int w);
        set_in(w, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(w, 1'b0, 1'b0, 1'b1);
    endtask

    // Consume n digits; optionally stall on one digit or poke start after one.
    task automatic run_stream(input int w, input int n, input int stall_idx, input int poke_idx);
        int n_full;
        int lat;
        int prev_accept;
        int waited;
        int bad;
        int expd;
        logic [8:0] o;
        n_full = (w == 0) ? 31 : 9;
        lat    = (w == 0) ? 353 : 385;
        prev_accept = -1;
        for (int k = 0; k < n; k++) begin
            expd   = (w == 0) ? exp_dec[k] : exp_hex[k];
            waited = 0;
            o = out_vec(w);
            while (!o[8] && waited < 1000) begin
                tick();
                waited++;
                o = out_vec(w);
            end
            if (!o[8]) begin
                check_val($sformatf("w%0d_timeout_dig%0d", w, k), 32'(o[8]), 1);
                return;
            end
            check_val($sformatf("w%0d_digit%0d", w, k), 32'(o[7:4]), expd);
            check_val($sformatf("w%0d_first%0d", w, k), 32'(o[3]), (k == 0) ? 1 : 0);
            check_val($sformatf("w%0d_last%0d", w, k), 32'(o[2]), (k == n_full - 1) ? 1 : 0);
            if (prev_accept >= 0)
                check_val($sformatf("w%0d_latency%0d", w, k), cyc - prev_accept, lat);
            if (k == stall_idx) begin
                set_in(w, 1'b0, 1'b0, 1'b0);
                bad = 0;
                for (int s = 0; s < 50; s++) begin
                    tick();
                    o = out_vec(w);
                    if (!o[8] || o[7:4] != 4'(expd) || o[3] || o[2]) bad++;
                end
                check_val($sformatf("w%0d_stall_hold%0d", w, k), bad, 0);
                set_in(w, 1'b0, 1'b0, 1'b1);
            end
            prev_accept = cyc;
            tick();
            if (k == poke_idx) begin
                set_in(w, 1'b1, 1'b0, 1'b1);
                tick();
                set_in(w, 1'b0, 1'b0, 1'b1);
            end
        end
        if (n == n_full) begin
            o = out_vec(w);
            check_val($sformatf("w%0d_done_after", w), 32'(o[0]), 1);
            check_val($sformatf("w%0d_busy_after", w), 32'(o[1]), 0);
            check_val($sformatf("w%0d_valid_after", w), 32'(o[8]), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_in(0, 1'b0, 1'b0, 1'b1);
        set_in(1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check_val("reset_outs_dec", 32'(out_vec(0)), 0);
        check_val("reset_outs_hex", 32'(out_vec(1)), 0);
        rst_n = 1'b1;
        tick();

        // Hex stream.
        pulse_start(1);
        run_stream(1, 9, -1, -1);

        // Decimal stream with a 50-cycle stall on the "8" (index 3).
        pulse_start(0);
        run_stream(0, 31, 3, -1);

        // Abort during the 5th digit's divide, then restart.
        pulse_start(0);
        run_stream(0, 4, -1, -1);
        repeat (4) tick();
        check_val("pre_abort_busy", 32'(out_vec(0) & 9'h002), 2);
        set_in(0, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(0, 1'b0, 1'b0, 1'b1);
        check_val("abort_busy", 32'(out_vec(0) & 9'h002), 0);
        check_val("abort_valid", 32'(out_vec(0) >> 8), 0);
        repeat (3) tick();
        check_val("abort_stays_idle", 32'(out_vec(0)), 0);
        pulse_start(0);
        run_stream(0, 3, -1, -1);

        // One-cycle reset in the middle of a divide.
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_val("midrun_reset_outs", 32'(out_vec(0)), 0);
        rst_n = 1'b1;
        tick();

        // Full run with a stray start pulse, then a restart from DONE.
        pulse_start(0);
        run_stream(0, 31, -1, 2);
        pulse_start(0);
        run_stream(0, 31, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spigot_e_engine.md
SPIGOT_E_ENGINE -- requirements
Module: spigot_e_engine

Interface
REQ-001 SHALL have parameter NTERMS, default 32: mixed-radix cells a[2..NTERMS+1] held in the engine.
REQ-002 SHALL have parameter RADIX, default 10: output base (10 = decimal, 16 = hex); legal range 2..16.
REQ-003 SHALL have parameter NDIGITS, default 30: fractional digits emitted per run; legal range 1..255.
REQ-004 SHALL derive localparams CW = clog2(NTERMS+2), XW = clog2(RADIX*(NTERMS+2)), DGW = clog2(RADIX).
REQ-005 Ports (clock and reset first), all SHALL be as listed:
  clk  in  1  single clock, rising edge
  rst_n  in  1  synchronous, active-low reset
  start  in  1  begin a run; sampled only in IDLE or DONE
  abort  in  1  return to IDLE from any state
  out_ready  in  1  consumer accepts digit
  out_valid  out  1  digit available
  out_digit  out  DGW  digit value, 0..RADIX-1
  out_first  out  1  qualifies the integer digit (2)
  out_last  out  1  qualifies the final fractional digit
  busy  out  1  high in every state except IDLE and DONE
  done  out  1  high in DONE

Function
REQ-006 SHALL compute e by the spigot: e = 2 + 1/2(1 + 1/3(1 + 1/4(...))), all cells initialised to 1.
REQ-007 SHALL use states IDLE, INIT, HEAD, LOAD, DIV, STORE, EMIT, DONE.
REQ-008 IDLE/DONE with start=1 SHALL go to INIT; start is ignored in every other state.
REQ-009 INIT SHALL set all cells to 1, q=0, digit count=0, i=NTERMS+1 in one cycle, then go to HEAD.
REQ-010 HEAD SHALL drive out_valid=1, out_digit=2, out_first=1; on out_valid&&out_ready go to LOAD.
REQ-011 LOAD SHALL form x = RADIX*a[i] + q (XW bits, no overflow by construction), start the divider with divisor i, then go to DIV.
REQ-012 DIV SHALL last exactly XW cycles, then go to STORE.
REQ-013 STORE SHALL write a[i] <= x mod i and q <= x div i; if i==2 go to EMIT, else decrement i and go to LOAD.
REQ-014 EMIT SHALL drive out_valid=1, out_digit=q, out_last=(count==NDIGITS-1).
REQ-015 On EMIT handshake: count++; if count reaches NDIGITS go to DONE, else q<=0, i<=NTERMS+1, go to LOAD.
REQ-016 Per-digit latency SHALL be exactly NTERMS*(XW+2)+1 cycles from an accepting handshake to the next out_valid rise.
REQ-017 While out_valid=1 and out_ready=0, out_digit, out_first and out_last SHALL stay stable; out_valid SHALL NOT drop before acceptance.
REQ-018 out_valid SHALL be 0 in all states except HEAD and EMIT; out_first and out_last SHALL be 0 whenever out_valid=0.
REQ-019 abort=1 SHALL force IDLE on the next edge and override start and handshake; cell contents are don't-care afterwards.
REQ-020 DONE SHALL hold until start (new run) or abort (go to IDLE).
REQ-021 A fractional digit exceeding RADIX-1 SHALL NOT occur for NDIGITS <= floor(log_RADIX(NTERMS!)) - 2; configurations outside this bound are illegal.

Reset
REQ-022 When rst_n=0 at a clock edge, the engine SHALL go to IDLE and clear q, i and count; rst_n SHALL take precedence over abort and start.
REQ-023 After reset, out_valid, out_digit, out_first, out_last, busy and done SHALL all be 0; cell contents need no reset.
REQ-024 Reset asserted mid-run SHALL take effect on that edge, including during DIV; the divider SHALL also reset.

Structure
REQ-025 Package spigot_pkg SHALL hold the state enum, a clog2 function, and the default NTERMS/RADIX/NDIGITS values.
REQ-026 Division SHALL be one sub-module, spigot_divmod: restoring divider, XW-bit dividend, CW-bit divisor, start/done pulses, XW cycles per division.
REQ-027 Cells SHALL be a flop array indexed by i; no SRAM macro.

Verification
REQ-028 Defaults, out_ready=1: digit stream SHALL be 2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3,6,0,2,8,7,4,7,1,3,5,2; out_first only on "2", out_last only on the final "2"; done=1 afterwards.
REQ-029 RADIX=16, NDIGITS=8: stream SHALL be 2,B,7,E,1,5,1,6,2.
REQ-030 Defaults (XW=9): the gap between the 2nd and 3rd out_valid rises SHALL be 353 cycles; with out_ready held low 50 cycles on digit "8", out_digit SHALL stay 8 throughout and the next digit SHALL not arrive early.
REQ-031 abort during the 5th digit's DIV, then start: busy=0 the cycle after abort; restarted stream SHALL begin 2,7,1.
REQ-032 rst_n low for 1 cycle mid-DIV: all outputs 0 the next cycle; start pulsed during a run SHALL be ignored; start in DONE SHALL reproduce the full REQ-028 stream.
